// File: rtl/pe_grid_pkg.sv
// Shared defaults, widths and FSM encoding for the PE grid operand feeder.
package pe_grid_pkg;

    localparam int unsigned DefCols  = 14;
    localparam int unsigned DefRows  = 12;
    localparam int unsigned DefDataW = 16;
    localparam int unsigned DefKBase = 0;
    localparam int unsigned DefIBase = 64;

    localparam int unsigned AddrW = 10;
    localparam int unsigned DimW  = 4;

    typedef enum logic [2:0] {
        StIdle,
        StWFetch,
        StWPulse,
        StWGap,
        StIFetch,
        StIPulse,
        StIGap,
        StDone
    } feeder_state_e;

    function automatic logic [DimW-1:0] clamp_dim(input logic [DimW-1:0] req,
                                                  input int unsigned lim);
        return (32'(req) > lim) ? DimW'(lim) : req;
    endfunction

endpackage

// File: rtl/pe_grid_feeder_if.sv
// Control, operand-memory and grid-side signals of the feeder; the abort input exists only
// when FEEDER_ABORT_EN is defined.
interface pe_grid_feeder_if #(
    parameter int unsigned COLS   = pe_grid_pkg::DefCols,
    parameter int unsigned DATA_W = pe_grid_pkg::DefDataW
);
    logic              start;
    logic [3:0]        k_rows;
    logic [3:0]        k_cols;
`ifdef FEEDER_ABORT_EN
    logic              abort;
`endif
    logic              mem_rd_en;
    logic [9:0]        mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] row_weight_vals [COLS];
    logic [3:0]        tag_row;
    logic              valid_y;
    logic [DATA_W-1:0] image_val_vec [COLS];
    logic              valid_x_vec [COLS];
    logic              busy;
    logic              done;

    // Host / memory / grid side.
    modport master (
`ifdef FEEDER_ABORT_EN
        output abort,
`endif
        output start, k_rows, k_cols, mem_rdata,
        input  mem_rd_en, mem_addr, row_weight_vals, tag_row, valid_y,
        input  image_val_vec, valid_x_vec, busy, done
    );

    // Feeder side.
    modport slave (
`ifdef FEEDER_ABORT_EN
        input  abort,
`endif
        input  start, k_rows, k_cols, mem_rdata,
        output mem_rd_en, mem_addr, row_weight_vals, tag_row, valid_y,
        output image_val_vec, valid_x_vec, busy, done
    );
endinterface

// File: rtl/feeder_row_buf.sv
// Staging row for one fetched kernel or image row: clear plus per-column write enable.
module feeder_row_buf
    import pe_grid_pkg::*;
#(
    parameter int unsigned COLS   = DefCols,
    parameter int unsigned DATA_W = DefDataW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              we_i,
    input  logic [DimW-1:0]   wsel_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] row_o [COLS]
);

    logic [DATA_W-1:0] slot_q [COLS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < COLS; c++) slot_q[c] <= '0;
        end else if (clr_i) begin
            for (int c = 0; c < COLS; c++) slot_q[c] <= '0;
        end else if (we_i) begin
            for (int c = 0; c < COLS; c++) begin
                if (wsel_i == DimW'(c)) slot_q[c] <= wdata_i;
            end
        end
    end

    assign row_o = slot_q;

endmodule

// File: rtl/pe_grid_feeder.sv
// Loads k_rows kernel rows then k_rows image rows from operand memory into the PE grid.
// Define FEEDER_ABORT_EN to add the abort input that drops any load back to idle.
module pe_grid_feeder
    import pe_grid_pkg::*;
#(
    parameter int unsigned COLS   = DefCols,
    parameter int unsigned ROWS   = DefRows,
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned KBASE  = DefKBase,
    parameter int unsigned IBASE  = DefIBase
) (
    input logic             clk,
    input logic             rst,
    pe_grid_feeder_if.slave bus_io
);

    feeder_state_e     state_q, state_d;
    logic [DimW-1:0]   kr_q, kr_d, kc_q, kc_d;
    logic [DimW-1:0]   row_q, row_d, cnt_q, cnt_d, tag_q, tag_d;
    logic [AddrW-1:0]  ptr_q, ptr_d;
    logic [DimW-1:0]   col_q;
    logic              rd_valid_q;
    logic              rd_en, clr;
    logic [DATA_W-1:0] stage [COLS];
    logic [DATA_W-1:0] w_hold_q [COLS];
    logic [DATA_W-1:0] x_hold_q [COLS];

    always_comb begin
        state_d = state_q;
        kr_d    = kr_q;
        kc_d    = kc_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        tag_d   = tag_q;
        ptr_d   = ptr_q;
        rd_en   = 1'b0;
        clr     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus_io.start) begin
                    kr_d    = clamp_dim(bus_io.k_rows, ROWS);
                    kc_d    = clamp_dim(bus_io.k_cols, COLS);
                    row_d   = '0;
                    cnt_d   = '0;
                    ptr_d   = AddrW'(KBASE);
                    clr     = 1'b1;
                    state_d = (kr_d == '0 || kc_d == '0) ? StDone : StWFetch;
                end
            end
            StWFetch, StIFetch: begin
                // Reads at cnt < kc, then one drain cycle while the last word lands.
                if (cnt_q < kc_q) begin
                    rd_en = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    ptr_d = ptr_q + 1'b1;
                end else begin
                    cnt_d   = '0;
                    state_d = (state_q == StWFetch) ? StWPulse : StIPulse;
                    if (state_q == StWFetch) tag_d = row_q;
                end
            end
            StWPulse: state_d = StWGap;
            StIPulse: state_d = StIGap;
            StWGap: begin
                if (row_q == kr_q - 1'b1) begin
                    row_d   = '0;
                    ptr_d   = AddrW'(IBASE);
                    state_d = StIFetch;
                end else begin
                    row_d   = row_q + 1'b1;
                    state_d = StWFetch;
                end
            end
            StIGap: begin
                if (row_q == kr_q - 1'b1) begin
                    state_d = StDone;
                end else begin
                    row_d   = row_q + 1'b1;
                    state_d = StIFetch;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
`ifdef FEEDER_ABORT_EN
        if (bus_io.abort && state_q != StIdle) begin
            state_d = StIdle;
            rd_en   = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            kr_q       <= '0;
            kc_q       <= '0;
            row_q      <= '0;
            cnt_q      <= '0;
            tag_q      <= '0;
            ptr_q      <= '0;
            col_q      <= '0;
            rd_valid_q <= 1'b0;
            for (int c = 0; c < COLS; c++) begin
                w_hold_q[c] <= '0;
                x_hold_q[c] <= '0;
            end
        end else begin
            state_q    <= state_d;
            kr_q       <= kr_d;
            kc_q       <= kc_d;
            row_q      <= row_d;
            cnt_q      <= cnt_d;
            tag_q      <= tag_d;
            ptr_q      <= ptr_d;
            col_q      <= cnt_q;
            rd_valid_q <= rd_en;
            if (state_q == StWPulse) w_hold_q <= stage;
            if (state_q == StIPulse) x_hold_q <= stage;
        end
    end

    feeder_row_buf #(
        .COLS   (COLS),
        .DATA_W (DATA_W)
    ) u_row_buf (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clr),
        .we_i    (rd_valid_q),
        .wsel_i  (col_q),
        .wdata_i (bus_io.mem_rdata),
        .row_o   (stage)
    );

    // Pulses show the staging row directly; the hold copies keep it visible afterwards.
    always_comb begin
        for (int c = 0; c < COLS; c++) begin
            bus_io.row_weight_vals[c] = (state_q == StWPulse) ? stage[c] : w_hold_q[c];
            bus_io.image_val_vec[c]   = (state_q == StIPulse) ? stage[c] : x_hold_q[c];
            bus_io.valid_x_vec[c]     = (state_q == StIPulse) && (32'(kc_q) > c);
        end
    end

    assign bus_io.mem_rd_en = rd_en;
    assign bus_io.mem_addr  = rd_en ? ptr_q : '0;
    assign bus_io.tag_row   = tag_q;
    assign bus_io.valid_y   = (state_q == StWPulse);
    assign bus_io.busy      = (state_q != StIdle);
    assign bus_io.done      = (state_q == StDone);

endmodule

// File: tb/tb_pe_grid_feeder.sv
// Randomized self-checking bench for pe_grid_feeder against a cycle-schedule reference model.
module tb_pe_grid_feeder;
    import pe_grid_pkg::*;

    localparam int unsigned COLS   = 14;
    localparam int unsigned ROWS   = 12;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned KBASE  = 0;
    localparam int unsigned IBASE  = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pe_grid_feeder_if #(.COLS(COLS), .DATA_W(DATA_W)) bus ();

    pe_grid_feeder #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .DATA_W (DATA_W),
        .KBASE  (KBASE),
        .IBASE  (IBASE)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    logic [DATA_W-1:0] mem [1024];
    logic [DATA_W-1:0] rdata_q = '0;
    always @(posedge clk) if (bus.mem_rd_en) rdata_q <= mem[bus.mem_addr];
    assign bus.mem_rdata = rdata_q;

    int n_chk  = 0;
    int n_pass = 0;

    int           w_cyc[$], w_tag[$], x_cyc[$], rd_addr[$];
    logic [255:0] w_row[$], x_row[$];
    logic [15:0]  x_mask[$];
    logic [255:0] last_w, last_x;
    logic         have_w, have_x;
    int done_cyc, done_cnt, overlap_cnt, busy_bad, hold_bad, first_row_reads;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [255:0] pack_w();
        logic [255:0] v;
        v = '0;
        for (int c = 0; c < COLS; c++) v[c*DATA_W +: DATA_W] = bus.row_weight_vals[c];
        return v;
    endfunction

    function automatic logic [255:0] pack_x();
        logic [255:0] v;
        v = '0;
        for (int c = 0; c < COLS; c++) v[c*DATA_W +: DATA_W] = bus.image_val_vec[c];
        return v;
    endfunction

    function automatic logic [15:0] mask_x();
        logic [15:0] m;
        m = '0;
        for (int c = 0; c < COLS; c++) m[c] = bus.valid_x_vec[c];
        return m;
    endfunction

    function automatic logic any_out();
        return bus.busy | bus.done | bus.valid_y | bus.mem_rd_en | (|bus.mem_addr) |
               (|bus.tag_row) | (|pack_w()) | (|pack_x()) | (|mask_x());
    endfunction

    // Row r of a region: words base + r*kc + c for c < kc, zero beyond.
    function automatic logic [255:0] exp_row(input int base, input int r, input int kc);
        logic [255:0] v;
        v = '0;
        for (int c = 0; c < kc; c++) v[c*DATA_W +: DATA_W] = mem[base + r*kc + c];
        return v;
    endfunction

    task automatic mon_cycle(input int n);
        logic [255:0] w, x;
        logic [15:0]  m;
        w = pack_w();
        x = pack_x();
        m = mask_x();
        if (bus.valid_y && m != '0) overlap_cnt++;
        if (bus.valid_y) begin
            w_cyc.push_back(n); w_tag.push_back(int'(bus.tag_row)); w_row.push_back(w);
            last_w = w; have_w = 1'b1;
        end else if (have_w && w != last_w) hold_bad++;
        if (m != '0) begin
            x_cyc.push_back(n); x_mask.push_back(m); x_row.push_back(x);
            last_x = x; have_x = 1'b1;
        end else if (have_x && x != last_x) hold_bad++;
        if (bus.mem_rd_en) begin
            rd_addr.push_back(int'(bus.mem_addr));
            if (w_cyc.size() == 0) first_row_reads++;
        end
        if (!bus.busy) busy_bad++;
        if (bus.done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = n;
        end
    endtask

    task automatic run_load(input int kr, input int kc, input bit gap_start);
        int kre, kce, per, exp_done, n, bad, nw;
        kre = (kr > int'(ROWS)) ? int'(ROWS) : kr;
        kce = (kc > int'(COLS)) ? int'(COLS) : kc;
        per = kce + 3;
        exp_done = (kre == 0 || kce == 0) ? 1 : 2*kre*per + 1;
        w_cyc.delete(); w_tag.delete(); w_row.delete();
        x_cyc.delete(); x_mask.delete(); x_row.delete(); rd_addr.delete();
        have_w = 1'b0; have_x = 1'b0;
        done_cyc = -1; done_cnt = 0; overlap_cnt = 0; busy_bad = 0; hold_bad = 0;
        first_row_reads = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.k_rows = 4'(kr); bus.k_cols = 4'(kc);
        n = 0;
        while (done_cyc < 0 && n < exp_done + 20) begin
            @(negedge clk);
            n++;
            mon_cycle(n);
            bus.start = 1'b0;
            if (gap_start && n == kce + 3) begin
                // Row 0 is in its gap cycle; this request must be ignored.
                bus.start = 1'b1; bus.k_rows = 4'd1; bus.k_cols = 4'd1;
            end
        end
        bus.start = 1'b0;
        check_eq("done_cycle", done_cyc, exp_done);
        @(negedge clk);
        check_eq("idle_after_done", {bus.busy, bus.done}, 2'b00);
        check_eq("rd_count", rd_addr.size(), 2*kre*kce);
        bad = 0;
        for (int i = 0; i < rd_addr.size(); i++) begin
            if (i < kre*kce) begin
                if (rd_addr[i] != int'(KBASE) + i) bad++;
            end else if (rd_addr[i] != int'(IBASE) + i - kre*kce) bad++;
        end
        check_eq("rd_addr_bad", bad, 0);
        if (kre > 0) check_eq("first_row_reads", first_row_reads, kce);
        check_eq("w_pulses", w_cyc.size(), (kce == 0) ? 0 : kre);
        check_eq("x_pulses", x_cyc.size(), (kce == 0) ? 0 : kre);
        nw = (w_cyc.size() < kre) ? w_cyc.size() : kre;
        for (int r = 0; r < nw; r++) begin
            check_eq("w_cycle", w_cyc[r], r*per + kce + 2);
            check_eq("w_tag", w_tag[r], r);
            check_eq("w_row", w_row[r], exp_row(int'(KBASE), r, kce));
        end
        nw = (x_cyc.size() < kre) ? x_cyc.size() : kre;
        for (int r = 0; r < nw; r++) begin
            check_eq("x_cycle", x_cyc[r], kre*per + r*per + kce + 2);
            check_eq("x_mask", x_mask[r], 16'((1 << kce) - 1));
            check_eq("x_row", x_row[r], exp_row(int'(IBASE), r, kce));
        end
        check_eq("overlap", overlap_cnt, 0);
        check_eq("hold", hold_bad, 0);
        check_eq("busy", busy_bad, 0);
        check_eq("done_count", done_cnt, 1);
    endtask

    task automatic rst_midload();
        int cnt;
        @(negedge clk);
        bus.start = 1'b1; bus.k_rows = 4'd2; bus.k_cols = 4'd3;
        @(negedge clk);
        bus.start = 1'b0;
        // Cycle 14 is the second read of image row 0 for a 2x3 load.
        repeat (13) @(negedge clk);
        check_eq("ifetch_addr", {bus.mem_rd_en, bus.mem_addr}, {1'b1, 10'(IBASE + 1)});
        rst = 1'b1;
        #1;
        check_eq("rst_mid_zero", any_out(), 1'b0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.busy) cnt++;
        end
        check_eq("rst_no_done", cnt, 0);
    endtask

    initial begin
        bus.start = 1'b0; bus.k_rows = '0; bus.k_cols = '0;
`ifdef FEEDER_ABORT_EN
        bus.abort = 1'b0;
`endif
        for (int i = 0; i < 1024; i++) mem[i] = DATA_W'(i);
        #1;
        check_eq("reset_zero", any_out(), 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        run_load(6, 6, 1'b0);
        check_eq("6x6_done_109", done_cyc, 109);
        check_eq("6x6_tag5", w_tag[5], 5);
        check_eq("6x6_r2_c0", w_row[2][15:0], 12);
        check_eq("6x6_r2_c5", w_row[2][95:80], 17);
        check_eq("6x6_r2_hi_zero", w_row[2][223:96], 0);
        check_eq("6x6_x3_c0", x_row[3][15:0], 82);
        check_eq("6x6_x3_c5", x_row[3][95:80], 87);
        check_eq("6x6_x3_mask", x_mask[3], 16'h003F);

        run_load(6, 6, 1'b1);

        for (int i = 0; i < 1024; i++) mem[i] = DATA_W'($urandom);
        run_load(13, 15, 1'b0);
        check_eq("clamp_w_pulses", w_cyc.size(), 12);
        check_eq("clamp_row_reads", first_row_reads, 14);

        run_load(0, 5, 1'b0);
        check_eq("zero_rows_done", done_cyc, 1);
        run_load(4, 0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            run_load(int'($urandom_range(1, 13)), int'($urandom_range(1, 15)), 1'b0);
        end

        rst_midload();

`ifdef FEEDER_ABORT_EN
        @(negedge clk);
        bus.start = 1'b1; bus.k_rows = 4'd3; bus.k_cols = 4'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("abort_in_wpulse", bus.valid_y, 1'b1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check_eq("abort_idle", {bus.busy, bus.valid_y, bus.done, bus.mem_rd_en}, 4'b0000);
        run_load(3, 3, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
